card_dealer_nrep: RTL and testbench
===================================

Name: card_dealer_nrep

Overview:
Parametrised card dealer. It holds a deck of DECK_SIZE distinct card values and deals them in random order without repetition until the deck is exhausted. Randomness comes from a free-running Galois LFSR, and deck slots are selected by rejection sampling. It is the next-generation replacement for the fixed 8-bit dealer in the card-game datapath, adding no-repeat dealing, a deck-count readout and an empty flag.

Parameters:
CARD_W, 8, width of card_o; must satisfy 2^CARD_W > DECK_SIZE.
DECK_SIZE, 52, number of cards; card values are 1..DECK_SIZE; minimum 2.
LFSR_W, 16, LFSR width; must be >= IDX_W.
LFSR_TAPS, 16'hB400, Galois feedback mask.
SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1.
MAX_TRIES, 7, rejected samples allowed before the fallback pick.
IDX_W, clog2(DECK_SIZE), localparam giving the slot index width.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  sampled high: refill the deck and restart dealing
req_i  in  1  level request; while held high, cards are dealt back-to-back
card_o  out  CARD_W  last dealt card value; 0 = none dealt yet
card_valid_o  out  1  one-cycle pulse when card_o is updated
remaining_o  out  IDX_W+1  cards left in the deck
empty_o  out  1  high when remaining_o == 0
busy_o  out  1  high in FILL or PICK

Behaviour:
- Reset (rst_i low), applied immediately and asynchronously:
  - state = IDLE.
  - card_o = 0, card_valid_o = 0, remaining_o = 0, empty_o = 1, busy_o = 0.
  - LFSR = SEED.
- LFSR advances every cycle after reset in every state and is never reloaded by start_i. Deal order therefore depends on request timing.
- Deck storage: DECK_SIZE x CARD_W register array. R = count register.
- States and transitions:
  - IDLE: wait for start_i.
  - FILL: write deck[i] = i+1, one slot per cycle, i = 0..DECK_SIZE-1. Takes DECK_SIZE cycles. After the final write, R = DECK_SIZE and go to READY.
  - READY: if req_i is high, go to PICK.
  - PICK: idx = LFSR[IDX_W-1:0].
    - If idx < R, latch j = idx and go to DEAL.
    - Otherwise increment the try counter. Once the counter has reached MAX_TRIES and the sample is still rejected, latch j = R-1 and go to DEAL.
  - DEAL, one cycle:
    - card_o <= deck[j].
    - deck[j] <= deck[R-1] (a no-op when j == R-1).
    - R <= R-1.
    - card_valid_o high during the following cycle.
    - Next state is EMPTY if R-1 == 0, otherwise READY.
  - EMPTY: req_i is ignored, card_o is held, wait for start_i.
- Latency: the req_i sample edge in READY is followed by card_valid_o high after a minimum of 3 edges and a maximum of 3+MAX_TRIES edges.
  - Holding req_i high produces one deal per READY/PICK/DEAL pass.
  - Dropping req_i during PICK or DEAL does not cancel that deal.
- start_i has priority over everything:
  - Sampled high in any state except FILL (including PICK and DEAL), it aborts the current activity, suppresses the pending card_valid_o, sets R = 0 and enters FILL.
  - start_i during FILL restarts the fill at slot 0.
  - start_i and req_i high in the same cycle: FILL wins.
- remaining_o = R; empty_o = (R == 0). Both read 0/1 throughout FILL until completion.
- card_o changes only at DEAL; there are no glitches between deals.
- Invariant: between fills, the set of dealt cards plus deck[0..R-1] is exactly {1..DECK_SIZE} with no duplicates.

Test Plan:
1. Reset low for 10 ns, release, pulse start_i -> busy_o high for 52 cycles; then remaining_o = 52, empty_o = 0, card_o = 0.
2. Hold req_i high after fill -> exactly 52 card_valid_o pulses, values form a permutation of 1..52, remaining_o decrements 52->0, then empty_o = 1. Further requests produce no pulses and card_o holds its value.
3. In EMPTY, pulse start_i, then deal 52 again -> second permutation differs from the first and is again a valid permutation.
4. Drive rst_i low while in PICK -> outputs take reset values in the same cycle with no clock edge; no card_valid_o afterward.
5. Assert start_i and req_i together in READY with remaining_o = 30 -> no card_valid_o, FILL entered, remaining_o = 52 afterward.
6. DECK_SIZE = 5, MAX_TRIES = 0, req_i held -> rejection/fallback path exercised, 5 pulses carrying a permutation of 1..5, each latency <= 3 edges.

Source files
------------

// File: rtl/card_dealer_nrep.sv
// Card dealer: deals the values 1..DECK_SIZE in LFSR-driven random order without repeats.
// Deck slots are chosen by rejection sampling, with a fallback pick after MAX_TRIES rejects.
module card_dealer_nrep #(
  parameter int                CARD_W    = 8,
  parameter int                DECK_SIZE = 52,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 7,
  localparam int               IDX_W     = $clog2(DECK_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              req_i,
  output logic [CARD_W-1:0] card_o,
  output logic              card_valid_o,
  output logic [IDX_W:0]    remaining_o,
  output logic              empty_o,
  output logic              busy_o
);

  localparam logic [LFSR_W-1:0] SEED_NZ   = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam int                TRY_W     = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(DECK_SIZE - 1);
  localparam logic [IDX_W:0]    FULL      = (IDX_W + 1)'(DECK_SIZE);

  typedef enum logic [2:0] {IDLE, FILL, READY, PICK, DEAL, EMPTY} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [IDX_W:0]      r_q;
  logic [IDX_W:0]      r_dec;
  logic [IDX_W-1:0]    r_m1;
  logic [IDX_W-1:0]    fill_q;
  logic [IDX_W-1:0]    j_q;
  logic [IDX_W-1:0]    sample;
  logic [TRY_W-1:0]    tries_q;
  logic [CARD_W-1:0]   deck [DECK_SIZE];
  logic                hit, fill_wr, take, take_fb, deal;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  assign sample = lfsr_q[IDX_W-1:0];
  assign hit    = {1'b0, sample} < r_q;
  assign r_dec  = r_q - 1'b1;
  assign r_m1   = r_dec[IDX_W-1:0];

  // start_i overrides every state, so a pending pick or deal never commits
  always_comb begin
    state_d = state_q;
    fill_wr = 1'b0;
    take    = 1'b0;
    take_fb = 1'b0;
    deal    = 1'b0;
    if (start_i) begin
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE, EMPTY: state_d = state_q;
        FILL: begin
          fill_wr = 1'b1;
          if (fill_q == LAST_SLOT) state_d = READY;
        end
        READY: if (req_i) state_d = PICK;
        PICK: begin
          if (hit) begin
            take    = 1'b1;
            state_d = DEAL;
          end else if (tries_q == TRY_MAX) begin
            take_fb = 1'b1;
            state_d = DEAL;
          end
        end
        DEAL: begin
          deal    = 1'b1;
          state_d = (r_dec == '0) ? EMPTY : READY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_q       <= SEED_NZ;
      r_q          <= '0;
      fill_q       <= '0;
      tries_q      <= '0;
      card_o       <= '0;
      card_valid_o <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_step(lfsr_q);
      card_valid_o <= deal;
      if (start_i) begin
        r_q    <= '0;
        fill_q <= '0;
      end
      if (fill_wr) begin
        fill_q <= (fill_q == LAST_SLOT) ? '0 : fill_q + 1'b1;
        if (fill_q == LAST_SLOT) r_q <= FULL;
      end
      if (state_q == READY) tries_q <= '0;
      else if (state_q == PICK && !take && !take_fb) tries_q <= tries_q + 1'b1;
      if (deal) begin
        card_o <= deck[j_q];
        r_q    <= r_dec;
      end
    end
  end

  // Dealt slot is refilled from the last live slot, keeping deck[0..R-1] dense
  always_ff @(posedge clk_i) begin
    if (take)         j_q <= sample;
    else if (take_fb) j_q <= r_m1;
    if (fill_wr)   deck[fill_q] <= CARD_W'(fill_q) + CARD_W'(1);
    else if (deal) deck[j_q]    <= deck[r_m1];
  end

  assign remaining_o = r_q;
  assign empty_o     = (r_q == '0);
  assign busy_o      = (state_q == FILL) || (state_q == PICK);

endmodule

// File: tb/tb_card_dealer_nrep.sv
// Bench for card_dealer_nrep: a 52-card and a 5-card (immediate fallback) instance,
// predicted by a transaction-level deck model and checked by a scoreboard monitor.
module tb_card_dealer_nrep;

  typedef struct {
    int card;
    int edge_n;
    int rem;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, req0 = 1'b0, start5 = 1'b0, req5 = 1'b0;
  logic [7:0] card0, card5;
  logic       valid0, valid5, empty0, empty5, busy0, busy5;
  logic [6:0] rem0;
  logic [3:0] rem5;

  int   cnt;
  int   nvec = 0;
  int   nfail = 0;
  exp_t q0[$];
  exp_t q5[$];
  int   got0[$];
  int   got5[$];
  int   first_perm[$];
  int   deck_m[2][64];
  int   r_m[2];
  int   cur_m[2];
  int   last_m[2];

  card_dealer_nrep dut0 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start0), .req_i(req0),
    .card_o(card0), .card_valid_o(valid0), .remaining_o(rem0),
    .empty_o(empty0), .busy_o(busy0)
  );

  card_dealer_nrep #(.DECK_SIZE(5), .MAX_TRIES(0)) dut5 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start5), .req_i(req5),
    .card_o(card5), .card_valid_o(valid5), .remaining_o(rem5),
    .empty_o(empty5), .busy_o(busy5)
  );

  always #5 clk = ~clk;

  // Edges elapsed since reset release; the LFSR state is a pure function of this
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else        cnt <= cnt + 1;
  end

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int w, input logic v);
    if (w != 0) req5 = v;
    else        req0 = v;
  endtask

  task automatic set_start(input int w, input logic v);
    if (w != 0) start5 = v;
    else        start0 = v;
  endtask

  // Deal k cards with req held from READY-sample edge a; push expected card, edge and count
  task automatic model_deal(input int w, input int a, input int k, output int last_d);
    int p, tries, idx, j, msk, mt;
    bit found;
    exp_t e;
    msk = (w != 0) ? 7 : 63;
    mt  = (w != 0) ? 0 : 7;
    p = a;
    last_d = a;
    for (int c = 0; c < k && r_m[w] > 0; c++) begin
      tries = 0;
      found = 0;
      j = 0;
      while (!found) begin
        p++;
        idx = int'(lfsr_at(p - 1)) & msk;
        if (idx < r_m[w]) begin
          j = idx;
          found = 1;
        end else if (tries == mt) begin
          j = r_m[w] - 1;
          found = 1;
        end else begin
          tries++;
        end
      end
      e.card   = deck_m[w][j];
      e.edge_n = p + 1;
      e.rem    = r_m[w] - 1;
      deck_m[w][j] = deck_m[w][r_m[w] - 1];
      r_m[w]--;
      last_m[w] = e.card;
      if (w != 0) q5.push_back(e);
      else        q0.push_back(e);
      last_d = e.edge_n;
      p = e.edge_n + 1;
    end
  endtask

  task automatic check_out(input int w, input logic v, input int card, input int rem);
    exp_t e;
    int   qs;
    qs = (w != 0) ? q5.size() : q0.size();
    if (v) begin
      if (qs == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_valid[%0d]: card %0d at edge %0d, none required", w, card, cnt);
        cur_m[w] = card;
      end else begin
        if (w != 0) e = q5.pop_front();
        else        e = q0.pop_front();
        chk("card_value", card, e.card);
        chk("valid_edge", cnt, e.edge_n);
        chk("remaining_after_deal", rem, e.rem);
        if (w != 0) got5.push_back(card);
        else        got0.push_back(card);
        cur_m[w] = e.card;
      end
    end else begin
      chk("card_hold", card, cur_m[w]);
      if (qs > 0) begin
        e = (w != 0) ? q5[0] : q0[0];
        if (cnt > e.edge_n) begin
          nvec++;
          nfail++;
          $display("FAIL missing_valid[%0d]: no pulse by edge %0d, required card %0d", w, cnt, e.card);
          if (w != 0) void'(q5.pop_front());
          else        void'(q0.pop_front());
        end
      end
    end
  endtask

  initial begin
    cur_m[0] = 0;
    cur_m[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_m[0] = 0;
        cur_m[1] = 0;
      end else begin
        check_out(0, valid0, int'(card0), int'(rem0));
        check_out(1, valid5, int'(card5), int'(rem5));
      end
    end
  end

  task automatic fill(input int w, input bit with_req);
    int nb, ds;
    ds = (w != 0) ? 5 : 52;
    set_start(w, 1'b1);
    if (with_req) set_req(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    set_req(w, 1'b0);
    nb = 0;
    for (int i = 0; i < ds + 2; i++) begin
      if ((w != 0) ? busy5 : busy0) nb++;
      if (i == 1) begin
        chk("remaining_in_fill", (w != 0) ? int'(rem5) : int'(rem0), 0);
        chk("empty_in_fill", (w != 0) ? int'(empty5) : int'(empty0), 1);
      end
      tick();
    end
    chk("busy_cycles", nb, ds);
    chk("remaining_full", (w != 0) ? int'(rem5) : int'(rem0), ds);
    chk("empty_full", (w != 0) ? int'(empty5) : int'(empty0), 0);
    for (int i = 0; i < ds; i++) deck_m[w][i] = i + 1;
    r_m[w] = ds;
  endtask

  task automatic deal_chunk(input int w, input int k, input bit early);
    int a, last_d, guard;
    a = cnt + 1;
    set_req(w, 1'b1);
    model_deal(w, a, k, last_d);
    if (early) begin
      tick();
      set_req(w, 1'b0);
    end
    guard = 0;
    while (cnt < last_d && guard < 4000) begin
      tick();
      guard++;
    end
    set_req(w, 1'b0);
    tick();
    chk("queue_drained", (w != 0) ? q5.size() : q0.size(), 0);
  endtask

  task automatic deal_random(input int n);
    int dealt, k;
    dealt = 0;
    while (dealt < n && r_m[0] > 0) begin
      k = $urandom_range(1, 8);
      if (k > n - dealt) k = n - dealt;
      deal_chunk(0, k, (k == 1) && ($urandom_range(0, 1) == 1));
      dealt += k;
      repeat ($urandom_range(0, 4)) tick();
    end
  endtask

  task automatic check_perm(input int w, input int ds);
    int bad, c, n;
    bit seen [64];
    bad = 0;
    for (int i = 0; i < 64; i++) seen[i] = 0;
    n = (w != 0) ? got5.size() : got0.size();
    chk("deck_count", n, ds);
    for (int i = 0; i < n; i++) begin
      c = (w != 0) ? got5[i] : got0[i];
      if (c < 1 || c > ds || seen[c]) bad++;
      else seen[c] = 1;
    end
    chk("permutation", bad, 0);
  endtask

  initial begin
    int same;
    r_m[0] = 0;
    r_m[1] = 0;
    last_m[0] = 0;
    last_m[1] = 0;
    #10;
    chk("rst_card", int'(card0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_remaining", int'(rem0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_busy", int'(busy0), 0);
    rst_n = 1'b1;
    tick();

    // Fill, then deal a whole deck in random chunks
    fill(0, 1'b0);
    chk("card_after_fill", int'(card0), 0);
    got0.delete();
    deal_random(52);
    check_perm(0, 52);
    first_perm = got0;
    chk("empty_after_deck", int'(empty0), 1);
    chk("remaining_after_deck", int'(rem0), 0);
    req0 = 1'b1;
    repeat (10) tick();
    req0 = 1'b0;
    tick();
    chk("card_held_in_empty", int'(card0), last_m[0]);

    // Refill from EMPTY and deal a second deck
    repeat ($urandom_range(1, 9)) tick();
    fill(0, 1'b0);
    got0.delete();
    deal_random(52);
    check_perm(0, 52);
    same = 1;
    for (int i = 0; i < 52 && i < got0.size(); i++) if (got0[i] != first_perm[i]) same = 0;
    chk("second_deck_differs", same, 0);

    // start_i and req_i together in READY with 30 left
    fill(0, 1'b0);
    deal_random(22);
    chk("remaining_30", int'(rem0), 30);
    fill(0, 1'b1);

    // Asynchronous reset while picking
    req0 = 1'b1;
    tick();
    chk("busy_in_pick", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_card", int'(card0), 0);
    chk("arst_valid", int'(valid0), 0);
    chk("arst_remaining", int'(rem0), 0);
    chk("arst_empty", int'(empty0), 1);
    chk("arst_busy", int'(busy0), 0);
    req0 = 1'b0;
    q0.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_after_arst", int'(busy0), 0);

    // Five-card instance: every reject falls straight back to the last slot
    fill(1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      got5.delete();
      deal_chunk(1, 5, 1'b0);
      check_perm(1, 5);
      chk("empty5", int'(empty5), 1);
      repeat ($urandom_range(0, 7)) tick();
      fill(1, 1'b0);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
